// File: rtl/arbitro_wrr_pkg.sv
// Shared types and helpers for the weighted round-robin FIFO scheduler.
package arbitro_wrr_pkg;

   localparam int NUM_PORTS     = 4;
   localparam int PORT_ID_WIDTH = 2;
   localparam int WORD_MAX      = 32;

   typedef enum logic {
      IDLE  = 1'b0,
      SERVE = 1'b1
   } state_t;

   // Destination field of a FIFO word, located at bit lsb.
   function automatic logic [PORT_ID_WIDTH-1:0] dest_of(input logic [WORD_MAX-1:0] word,
                                                         input int lsb);
      return PORT_ID_WIDTH'(word >> lsb);
   endfunction

endpackage

// File: rtl/arbitro_wrr_if.sv
// Bus between the FIFO banks and the scheduler; the scheduler owns pop/push.
interface arbitro_wrr_if
   import arbitro_wrr_pkg::*;
#(
   parameter int DATA_WIDTH   = 6,
   parameter int WEIGHT_WIDTH = 3
) ();

   logic [NUM_PORTS-1:0]              emptyFIFO;
   logic [NUM_PORTS-1:0]              almost_fullFIFO;
   logic [NUM_PORTS*DATA_WIDTH-1:0]   data_in;
   logic [NUM_PORTS*WEIGHT_WIDTH-1:0] weights;
   logic [NUM_PORTS-1:0]              pop;
   logic [NUM_PORTS-1:0]              push;
   logic [DATA_WIDTH-1:0]             data_out;
   logic [PORT_ID_WIDTH-1:0]          grant_id;
   logic                              idle;

   modport master (
      input  emptyFIFO, almost_fullFIFO, data_in, weights,
      output pop, push, data_out, grant_id, idle
   );

   modport slave (
      output emptyFIFO, almost_fullFIFO, data_in, weights,
      input  pop, push, data_out, grant_id, idle
   );

endinterface

// File: rtl/arbitro_wrr_rr_prio_pick.sv
// Rotating-priority picker: first set bit of elig searching start, start+1, ... mod 4.
module rr_prio_pick
   import arbitro_wrr_pkg::*;
(
   input  logic [NUM_PORTS-1:0]     elig,
   input  logic [PORT_ID_WIDTH-1:0] start,
   output logic [NUM_PORTS-1:0]     onehot,
   output logic [PORT_ID_WIDTH-1:0] idx,
   output logic                     found
);

   logic [PORT_ID_WIDTH-1:0] cand;

   // Walk the four positions from start and keep the first eligible one.
   always_comb begin
      onehot = '0;
      idx    = start;
      found  = 1'b0;
      cand   = start;
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
         cand = start + PORT_ID_WIDTH'(k);
         if (!found && elig[cand]) begin
            found        = 1'b1;
            idx          = cand;
            onehot[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/arbitro_wrr.sv
// Weighted round-robin scheduler moving head words from 4 source FIFOs to 4 destination FIFOs.
module arbitro_wrr
   import arbitro_wrr_pkg::*;
#(
   parameter int DATA_WIDTH   = 6,
   parameter int DEST_LSB     = 4,
   parameter int WEIGHT_WIDTH = 3
) (
   input  logic          clk,
   input  logic          reset,
   arbitro_wrr_if.master bus
);

   typedef logic [DATA_WIDTH-1:0]   word_t;
   typedef logic [WEIGHT_WIDTH-1:0] wt_t;

   state_t                   state;
   logic [PORT_ID_WIDTH-1:0] ptr;
   logic [PORT_ID_WIDTH-1:0] gnt;
   wt_t                      cnt;
   wt_t                      wt [NUM_PORTS];
   logic [NUM_PORTS-1:0]     push_q;
   word_t                    data_q;

   word_t                    head [NUM_PORTS];
   logic [PORT_ID_WIDTH-1:0] dest [NUM_PORTS];
   logic [NUM_PORTS-1:0]     elig;

   logic                     keep;
   logic [PORT_ID_WIDTH-1:0] pick_start;
   logic [NUM_PORTS-1:0]     pick_oh;
   logic [PORT_ID_WIDTH-1:0] pick_idx;
   logic                     pick_found;
   logic [NUM_PORTS-1:0]     pop_oh;
   logic                     pop_vld;
   logic [PORT_ID_WIDTH-1:0] pop_idx;

   // Split head words and flag each source whose word can go to a non-almost-full destination.
   always_comb begin
      elig = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         head[i] = bus.data_in[i*DATA_WIDTH +: DATA_WIDTH];
         dest[i] = dest_of(WORD_MAX'(head[i]), DEST_LSB);
         elig[i] = !bus.emptyFIFO[i] && !bus.almost_fullFIFO[dest[i]];
      end
   end

   // Stay on the current grant while it is eligible and has quantum left.
   always_comb begin
      keep       = (state == SERVE) && elig[gnt] && (cnt < wt[gnt]);
      pick_start = (state == SERVE) ? gnt + 2'd1 : ptr;
   end

   rr_prio_pick u_pick (
      .elig   (elig),
      .start  (pick_start),
      .onehot (pick_oh),
      .idx    (pick_idx),
      .found  (pick_found)
   );

   // Pop decision for this cycle; nothing is popped while reset is held.
   always_comb begin
      pop_oh = '0;
      if (!reset) begin
         pop_oh = keep ? (4'b0001 << gnt) : pick_oh;
      end
      pop_vld = |pop_oh;
      pop_idx = keep ? gnt : pick_idx;
   end

   // Grant FSM, quantum counter, weight latch and the registered push stage.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         ptr    <= '0;
         gnt    <= '0;
         cnt    <= '0;
         push_q <= '0;
         data_q <= '0;
         for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            wt[i] <= (bus.weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] == '0)
                     ? WEIGHT_WIDTH'(1)
                     : bus.weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
         end
      end else begin
         push_q <= pop_vld ? (4'b0001 << dest[pop_idx]) : '0;
         if (pop_vld) begin
            data_q <= head[pop_idx];
         end
         case (state)
            IDLE: begin
               if (pick_found) begin
                  gnt   <= pick_idx;
                  cnt   <= WEIGHT_WIDTH'(1);
                  state <= SERVE;
               end
            end
            SERVE: begin
               if (keep) begin
                  cnt <= cnt + 1'b1;
               end else begin
                  // The picker starts at gnt+1, so gnt itself is only reconsidered last.
                  ptr <= gnt + 2'd1;
                  if (pick_found) begin
                     gnt <= pick_idx;
                     cnt <= WEIGHT_WIDTH'(1);
                  end else begin
                     state <= IDLE;
                  end
               end
            end
         endcase
      end
   end

   // The in-flight word is dropped when reset arrives right after its pop.
   assign bus.push     = reset ? '0 : push_q;
   assign bus.pop      = pop_oh;
   assign bus.data_out = data_q;
   assign bus.grant_id = gnt;
   assign bus.idle     = !pop_vld;

endmodule

// File: doc/arbitro_wrr.md
Name: arbitro_wrr

Overview:
- Weighted round-robin scheduler between 4 input FIFOs (source classes 0-3) and 4 output FIFOs (destinations 0-3).
- Each cycle it pops at most one head word from a non-empty source and, one cycle later, pushes that word into the destination FIFO selected by the word's dest field.
- Output pushes are suppressed by destination almost_full backpressure.
- Sits between the input FIFO bank and the output FIFO bank; it owns all pop/push strobes.

Parameters:
- DATA_WIDTH, 6, FIFO word width.
- DEST_LSB, 4, LSB of the 2-bit destination field; dest = word[DEST_LSB+1:DEST_LSB].
- WEIGHT_WIDTH, 3, width of per-source weight (burst quantum).

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- emptyFIFO  input  4  empty flag per source FIFO.
- almost_fullFIFO  input  4  almost-full flag per destination FIFO. Asserted with at least 2 free slots remaining.
- data_in  input  4*DATA_WIDTH  show-ahead head words; source i at [i*DATA_WIDTH +: DATA_WIDTH]. Valid whenever emptyFIFO[i]=0.
- weights  input  4*WEIGHT_WIDTH  per-source quantum, sampled only while reset=1.
- pop  output  4  one-hot or zero pop strobe to source FIFOs.
- push  output  4  one-hot or zero push strobe to destination FIFOs.
- data_out  output  DATA_WIDTH  word accompanying push.
- grant_id  output  2  source currently owning the grant.
- idle  output  1  1 when no pop issued this cycle.

Behaviour:
- Reset (clk edge with reset=1):
  - pop=0, push=0, data_out=0, grant_id=0, idle=1.
  - RR pointer=0, burst counter=0, state=IDLE.
  - weights latched into internal regs; weight 0 is treated as 1.
- Eligibility: source i is eligible iff emptyFIFO[i]=0 and almost_fullFIFO[dest(data_in_i)]=0.
- pop is combinational from registered state and current inputs, asserted in the same cycle as the decision. FIFO consumes on the clk edge.
- push and data_out are registered: exactly 1-cycle latency from pop to push. push[d]=1 with d = dest of the popped word; data_out = that word.
- States:
  - IDLE: no grant. Search sources ptr, ptr+1, ... (mod 4); the first eligible source g is popped, grant_id<=g, cnt<=1, go to SERVE. If none is eligible, stay IDLE, pop=0.
  - SERVE (grant g): if g is eligible and cnt<weight[g], pop g again and cnt++.
  - SERVE, quantum exhausted (cnt==weight[g]) or g ineligible: ptr<=g+1 (mod 4) and re-arbitrate in the same cycle, starting at g+1. g may be regranted only after 3 other sources are checked. If another source is found: grant, cnt<=1, stay SERVE. If none is found: IDLE.
- Backpressure:
  - Checked per word against its own destination.
  - A blocked head word blocks its source only; other sources proceed (no head-of-line across sources).
  - The in-flight word is always pushed; the almost_full margin guarantees space.
- Simultaneous events: a new pop and the previous word's push occur in the same cycle at full rate (1 word/clk throughput).
- Reset mid-operation: the in-flight word is dropped (push=0 on the reset cycle and the next cycle), pop=0 during reset, and the pointer returns to 0.
- Counter width WEIGHT_WIDTH; the ptr wraps 3->0.

Decomposition:
- Shared package: NUM_PORTS=4, PORT_ID_WIDTH=2, state encoding (IDLE=0, SERVE=1), dest-field extraction function.
- One sub-module, rr_prio_pick: a combinational 4-way rotate-priority picker (eligible mask, start ptr -> one-hot, index, found).

Test Plan:
- Reset with weights=1,1,1,1; emptyFIFO=1111 -> pop=0000, push=0000, idle=1 for 5 cycles.
- Source 0 only non-empty, word 6'h25 (dest 2) -> pop=0001 cycle N; push=0100, data_out=6'h25 at cycle N+1.
- All sources non-empty, weights 2,1,1,3, all dest 0 -> pop sequence 0,0,1,2,3,3,3,0,0...; push=0001 each cycle after the first.
- almost_fullFIFO=1000, source 1 head dest 3, source 2 head dest 1 -> source 1 never popped; source 2 served continuously. Release almost_full -> source 1 popped within 4 cycles.
- almost_fullFIFO ramps 1000 -> 1100 -> 1110 with mixed dests -> only dest-0 words pushed once all three flags set; no push ever to a full-flagged dest after its flag was seen.
- Assert reset one cycle after pop=0010 -> push stays 0000, pop=0000; after release, arbitration restarts at source 0.
